eda_pixel_iterator: RTL and testbench



---
 rtl/eda_global_define.sv | 25 ++
 rtl/eda_pixel_iterator_if.sv | 29 ++
 rtl/eda_raster_counter.sv | 39 +++
 rtl/eda_pixel_iterator.sv | 108 ++++++++++
 tb/tb_eda_pixel_iterator.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eda_global_define.sv
// Shared widths and scan-FSM state encoding for the pixel iterator block.
// Build-time widths come from the CFG_* macros when the flow defines them.
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 4
`endif

package eda_global_define;

  localparam int unsigned CfgIWidth    = `CFG_I_WIDTH;
  localparam int unsigned CfgJWidth    = `CFG_J_WIDTH;
  // The pixel address is always {row, col}, so its width is the sum.
  localparam int unsigned CfgAddrWidth = CfgIWidth + CfgJWidth;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCheck,
    StHold,
    StDone
  } iter_state_e;

endpackage

// File: rtl/eda_pixel_iterator_if.sv
// Control and visited-RAM signals of the pixel iterator.
// The slave modport is the iterator; the master modport is the controller/RAM side.
interface eda_pixel_iterator_if #(
  parameter int unsigned I_WIDTH    = eda_global_define::CfgIWidth,
  parameter int unsigned J_WIDTH    = eda_global_define::CfgJWidth,
  parameter int unsigned ADDR_WIDTH = I_WIDTH + J_WIDTH
);
  logic                  start;
  logic [I_WIDTH-1:0]    last_row;
  logic [J_WIDTH-1:0]    last_col;
  logic                  take;
  logic                  vis_rd_en;
  logic [ADDR_WIDTH-1:0] vis_rd_addr;
  logic                  vis_rd_data;
  logic [I_WIDTH-1:0]    next_row;
  logic [J_WIDTH-1:0]    next_col;
  logic                  next_valid;
  logic                  iterated_all;

  modport slave (
    input  start, last_row, last_col, take, vis_rd_data,
    output vis_rd_en, vis_rd_addr, next_row, next_col, next_valid, iterated_all
  );

  modport master (
    output start, last_row, last_col, take, vis_rd_data,
    input  vis_rd_en, vis_rd_addr, next_row, next_col, next_valid, iterated_all
  );
endinterface

// File: rtl/eda_raster_counter.sv
// Raster-order (row, col) pointer: col counts to last_col, then wraps and row advances.
// Saturates at (last_row, last_col); clr returns to (0, 0).
module eda_raster_counter #(
  parameter int unsigned I_WIDTH = eda_global_define::CfgIWidth,
  parameter int unsigned J_WIDTH = eda_global_define::CfgJWidth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  input  logic [I_WIDTH-1:0] last_row,
  input  logic [J_WIDTH-1:0] last_col,
  output logic [I_WIDTH-1:0] row,
  output logic [J_WIDTH-1:0] col,
  output logic               is_last
);

  logic [I_WIDTH-1:0] row_q;
  logic [J_WIDTH-1:0] col_q;

  assign row     = row_q;
  assign col     = col_q;
  assign is_last = (row_q == last_row) && (col_q == last_col);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc && !is_last) begin
      if (col_q == last_col) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/eda_pixel_iterator.sv
// Walks an image in raster order, skipping pixels flagged in the visited RAM, and
// presents each unvisited pixel until the controller takes it.
module eda_pixel_iterator
  import eda_global_define::*;
#(
  parameter int unsigned I_WIDTH    = CfgIWidth,
  parameter int unsigned J_WIDTH    = CfgJWidth,
  parameter int unsigned ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
  input logic                 clk,
  input logic                 reset,
  eda_pixel_iterator_if.slave bus
);

  iter_state_e           state_q;
  logic [I_WIDTH-1:0]    lim_row_q;
  logic [J_WIDTH-1:0]    lim_col_q;
  logic                  rd_en_q;
  logic                  valid_q;
  logic                  done_q;
  logic                  inc;
  logic [I_WIDTH-1:0]    row;
  logic [J_WIDTH-1:0]    col;
  logic                  is_last;
  logic [ADDR_WIDTH-1:0] addr;

  eda_raster_counter #(
    .I_WIDTH (I_WIDTH),
    .J_WIDTH (J_WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc),
    .clr      (bus.start),
    .last_row (lim_row_q),
    .last_col (lim_col_q),
    .row      (row),
    .col      (col),
    .is_last  (is_last)
  );

  // Advance after a visited hit or a taken candidate; start clears instead.
  always_comb begin
    inc = 1'b0;
    if (!bus.start) begin
      if (state_q == StCheck) inc = bus.vis_rd_data && !is_last;
      if (state_q == StHold)  inc = bus.take && !is_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      lim_row_q <= '0;
      lim_col_q <= '0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.start) begin
      state_q   <= StFetch;
      lim_row_q <= bus.last_row;
      lim_col_q <= bus.last_col;
      rd_en_q   <= 1'b1;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StFetch: state_q <= StCheck;
        StCheck: begin
          if (!bus.vis_rd_data) begin
            state_q <= StHold;
            valid_q <= 1'b1;
          end else if (is_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StFetch;
            rd_en_q <= 1'b1;
          end
        end
        StHold: begin
          if (!bus.take) begin
            valid_q <= 1'b1;
          end else if (is_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StFetch;
            rd_en_q <= 1'b1;
          end
        end
        default: ;  // idle and done wait for start
      endcase
    end
  end

  assign addr             = {row, col};
  assign bus.vis_rd_en    = rd_en_q;
  assign bus.vis_rd_addr  = addr;
  assign bus.next_row     = row;
  assign bus.next_col     = col;
  assign bus.next_valid   = valid_q;
  assign bus.iterated_all = done_q;

endmodule

// File: tb/tb_eda_pixel_iterator.sv
// Bench for eda_pixel_iterator: a visited-RAM model with one-cycle read latency and a
// raster-order cycle model of candidates and the completion pulse.
module tb_eda_pixel_iterator;
  import eda_global_define::*;

  localparam int Stride = 1 << CfgJWidth;
  localparam int Pixels = (1 << CfgIWidth) * Stride;

  logic clk = 1'b0;
  logic reset = 1'b1;

  eda_pixel_iterator_if bus ();

  eda_pixel_iterator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit vis_mem [Pixels];
  int cand_addr[$];
  int cand_cyc[$];
  int done_cyc[$];
  int exp_addr[$];
  int exp_cyc[$];
  int exp_done;
  int hold_bad;
  int done_bad;
  bit timed_out;
  bit pend_v = 1'b0;
  bit pend = 1'b0;

  task automatic clear_map();
    foreach (vis_mem[i]) vis_mem[i] = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first FETCH cycle.
  task automatic kick(input int lr, input int lc);
    bus.start    = 1'b1;
    bus.take     = 1'b0;
    bus.last_row = lr[CfgIWidth-1:0];
    bus.last_col = lc[CfgJWidth-1:0];
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Cycle 0 is the current negedge. Serves RAM reads, takes candidates after
  // 'delay' extra hold cycles, and records what it sees.
  task automatic observe(input int delay, input int budget, input bit stop_cand);
    int hold_cnt = 0;
    int post = -1;
    int pr = 0;
    int pc = 0;
    cand_addr.delete();
    cand_cyc.delete();
    done_cyc.delete();
    hold_bad = 0;
    done_bad = 0;
    timed_out = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.vis_rd_data = pend_v ? pend : 1'($urandom);
      pend_v = bus.vis_rd_en;
      pend = vis_mem[int'(bus.vis_rd_addr)];
      bus.take = 1'b0;
      if (post >= 0 && (bus.next_valid || bus.vis_rd_en)) done_bad++;
      if (bus.iterated_all) begin
        done_cyc.push_back(cyc);
        if (post < 0) post = 5;
      end
      if (bus.next_valid) begin
        if (hold_cnt == 0) begin
          pr = int'(bus.next_row);
          pc = int'(bus.next_col);
          cand_addr.push_back(pr * Stride + pc);
          cand_cyc.push_back(cyc);
          if (stop_cand) return;
        end else if (int'(bus.next_row) != pr || int'(bus.next_col) != pc) begin
          hold_bad++;
        end
        if (bus.vis_rd_en) hold_bad++;
        if (hold_cnt == delay) bus.take = 1'b1;
        hold_cnt++;
      end else begin
        hold_cnt = 0;
        bus.take = 1'($urandom);  // must be ignored outside hold
      end
      if (post == 0) return;
      if (post > 0) post--;
    end
    timed_out = 1'b1;
  endtask

  // Raster walk: a visited pixel costs 2 cycles; an unvisited one appears 2 cycles
  // after its fetch and is held delay+1 cycles before the next fetch.
  task automatic scan_scenario(input string name, input int lr, input int lc, input int delay);
    int t = 0;
    int n;
    exp_addr.delete();
    exp_cyc.delete();
    for (int r = 0; r <= lr; r++) begin
      for (int c = 0; c <= lc; c++) begin
        if (vis_mem[r * Stride + c]) begin
          t += 2;
        end else begin
          exp_addr.push_back(r * Stride + c);
          exp_cyc.push_back(t + 2);
          t += 3 + delay;
        end
      end
    end
    exp_done = t;
    kick(lr, lc);
    observe(delay, 600, 1'b0);
    bus.take = 1'b0;
    total++;
    if (timed_out !== 1'b0) begin
      bad++;
      $display("FAIL %s timeout: got %0d want 0", name, timed_out);
    end
    total++;
    if (cand_addr.size() != exp_addr.size()) begin
      bad++;
      $display("FAIL %s cand_count: got %0d want %0d", name, cand_addr.size(), exp_addr.size());
    end
    n = (cand_addr.size() < exp_addr.size()) ? cand_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (cand_addr[i] != exp_addr[i]) begin
        bad++;
        $display("FAIL %s cand_addr[%0d]: got 0x%0h want 0x%0h", name, i, cand_addr[i],
                 exp_addr[i]);
      end
      total++;
      if (cand_cyc[i] != exp_cyc[i]) begin
        bad++;
        $display("FAIL %s cand_cycle[%0d]: got %0d want %0d", name, i, cand_cyc[i], exp_cyc[i]);
      end
    end
    total++;
    if (done_cyc.size() != 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cyc.size());
    end
    total++;
    if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", name,
               done_cyc.size() > 0 ? done_cyc[0] : -1, exp_done);
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL %s hold_stability: got %0d violations want 0", name, hold_bad);
    end
    total++;
    if (done_bad != 0) begin
      bad++;
      $display("FAIL %s done_quiet: got %0d active cycles want 0", name, done_bad);
    end
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    outs = {bus.vis_rd_en, bus.next_valid, bus.iterated_all, 13'(bus.vis_rd_addr)};
    total++;
    if (outs !== 16'h0) begin
      bad++;
      $display("FAIL reset_flags_addr: got 0x%0h want 0x0", outs);
    end
    total++;
    if ({bus.next_row, bus.next_col} !== '0) begin
      bad++;
      $display("FAIL reset_next_pos: got 0x%0h want 0x0", {bus.next_row, bus.next_col});
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.vis_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_beats_start: got rd_en=%0b want 0", bus.vis_rd_en);
    end
  endtask

  task automatic test_full_scan();
    clear_map();
    scan_scenario("full_4x4", 3, 3, 1);
  endtask

  task automatic test_skip_visited();
    clear_map();
    for (int p = 1; p <= 14; p++) vis_mem[(p / 4) * Stride + (p % 4)] = 1'b1;
    scan_scenario("skip_4x4", 3, 3, 0);
  endtask

  task automatic test_one_pixel();
    clear_map();
    scan_scenario("one_pixel", 0, 0, 0);
    repeat (10) @(negedge clk);
    total++;
    if ({bus.iterated_all, bus.next_valid, bus.vis_rd_en} !== 3'b000) begin
      bad++;
      $display("FAIL one_pixel_done_hold: got %03b want 000",
               {bus.iterated_all, bus.next_valid, bus.vis_rd_en});
    end
  endtask

  task automatic test_hold_stall();
    clear_map();
    for (int p = 0; p < 9; p++) vis_mem[(p / 4) * Stride + (p % 4)] = 1'b1;
    scan_scenario("stall_2_1", 3, 3, 10);
  endtask

  task automatic test_restart_in_hold();
    clear_map();
    for (int p = 0; p < 7; p++) vis_mem[(p / 4) * Stride + (p % 4)] = 1'b1;
    kick(3, 3);
    observe(0, 100, 1'b1);
    total++;
    if ((cand_addr.size() == 1 ? cand_addr[0] : -1) != 1 * Stride + 3) begin
      bad++;
      $display("FAIL restart_first_cand: got %0d want %0d",
               cand_addr.size() == 1 ? cand_addr[0] : -1, 1 * Stride + 3);
    end
    kick(1, 1);
    total++;
    if ({bus.vis_rd_en, bus.next_valid} !== 2'b10 || bus.vis_rd_addr !== '0) begin
      bad++;
      $display("FAIL restart_fetch: got en/valid=%02b addr=0x%0h want 10 addr=0x0",
               {bus.vis_rd_en, bus.next_valid}, bus.vis_rd_addr);
    end
    observe(0, 100, 1'b0);
    bus.take = 1'b0;
    total++;
    if (cand_addr.size() != 0 || timed_out) begin
      bad++;
      $display("FAIL restart_new_limits: got %0d cands timeout=%0b want 0 cands", cand_addr.size(),
               timed_out);
    end
    total++;
    if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != 8) begin
      bad++;
      $display("FAIL restart_done_cycle: got %0d want 8", done_cyc.size() > 0 ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_reset_mid_scan();
    int pulses = 0;
    int fetches = 0;
    clear_map();
    kick(3, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.vis_rd_en, bus.next_valid, bus.iterated_all} !== 3'b000 ||
        bus.vis_rd_addr !== '0) begin
      bad++;
      $display("FAIL reset_mid_check: got flags=%03b addr=0x%0h want 000 addr=0x0",
               {bus.vis_rd_en, bus.next_valid, bus.iterated_all}, bus.vis_rd_addr);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.vis_rd_data = 1'($urandom);
      bus.take = 1'($urandom);
      if (bus.iterated_all) pulses++;
      if (bus.vis_rd_en || bus.next_valid) fetches++;
    end
    bus.take = 1'b0;
    total++;
    if (pulses != 0 || fetches != 0) begin
      bad++;
      $display("FAIL reset_mid_idle: got pulses=%0d active=%0d want 0 0", pulses, fetches);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int lr = int'($urandom_range(0, 3));
      int lc = int'($urandom_range(0, 3));
      clear_map();
      for (int r = 0; r <= lr; r++)
        for (int c = 0; c <= lc; c++) vis_mem[r * Stride + c] = 1'($urandom);
      scan_scenario($sformatf("random_%0d", it), lr, lc, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.take = 1'b0;
    bus.vis_rd_data = 1'b0;
    bus.last_row = '0;
    bus.last_col = '0;
    test_reset();
    test_full_scan();
    test_skip_visited();
    test_one_pixel();
    test_hold_stall();
    test_restart_in_hold();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
